// File: rtl/rgb_pkg.sv
// Shared constants and types for the RGB LED arbiter: active-high colour codes and FSM states.
package rgb_pkg;

  localparam int unsigned COLOR_W = 3;

  localparam logic [COLOR_W-1:0] RGB_OFF = 3'b000;
  localparam logic [COLOR_W-1:0] RED     = 3'b100;
  localparam logic [COLOR_W-1:0] GREEN   = 3'b010;
  localparam logic [COLOR_W-1:0] BLUE    = 3'b001;
  localparam logic [COLOR_W-1:0] YELLOW  = 3'b110;
  localparam logic [COLOR_W-1:0] CYAN    = 3'b011;
  localparam logic [COLOR_W-1:0] MAGENTA = 3'b101;

  // Pin level that turns the active-low LED fully off
  localparam logic [COLOR_W-1:0] LED_DARK = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    GAP  = 2'd2
  } state_e;

endpackage

// File: rtl/rgb_led_arbiter_rr_pick.sv
// Combinational round-robin picker: searches upward from last_id+1, wrapping, for the first request.
module rr_pick #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    last_id,
  output logic               valid,
  output logic [ID_W-1:0]    win_id
);

  // Offset NUM_REQ lands back on last_id, so the previous winner is considered last
  always_comb begin
    valid  = 1'b0;
    win_id = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      if (!valid && req[(32'(last_id) + k) % NUM_REQ]) begin
        valid  = 1'b1;
        win_id = ID_W'((32'(last_id) + k) % NUM_REQ);
      end
    end
  end

endmodule

// File: rtl/rgb_led_arbiter.sv
// Shares one active-low RGB LED between NUM_REQ requesters: round-robin grant, hold colour, then blank gap.
module rgb_led_arbiter
  import rgb_pkg::*;
#(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned HOLD_CYCLES = 2000000,
  parameter int unsigned GAP_CYCLES  = 120000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [3*NUM_REQ-1:0]   color,
  output logic [NUM_REQ-1:0]     grant,
  output logic [NUM_REQ-1:0]     done,
  output logic                   busy,
  output logic                   RGB_R,
  output logic                   RGB_G,
  output logic                   RGB_B
);

  localparam int unsigned ID_W    = $clog2(NUM_REQ);
  localparam int unsigned CNT_MAX = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);

  state_e               state, state_nxt;
  logic [CNT_W-1:0]     count, count_nxt;
  logic [ID_W-1:0]      last_id, last_id_nxt;
  logic [NUM_REQ-1:0]   grant_nxt, done_nxt;
  logic                 busy_nxt;
  logic [COLOR_W-1:0]   led, led_nxt;
  logic                 pick_valid;
  logic [ID_W-1:0]      pick_id;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr_pick (
    .req     (req),
    .last_id (last_id),
    .valid   (pick_valid),
    .win_id  (pick_id)
  );

  // State, counter and all outputs are registered; led holds the inverted colour latched at grant
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      count   <= '0;
      last_id <= ID_W'(NUM_REQ - 1);
      grant   <= '0;
      done    <= '0;
      busy    <= 1'b0;
      led     <= LED_DARK;
    end else begin
      state   <= state_nxt;
      count   <= count_nxt;
      last_id <= last_id_nxt;
      grant   <= grant_nxt;
      done    <= done_nxt;
      busy    <= busy_nxt;
      led     <= led_nxt;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_nxt   = state;
    count_nxt   = count;
    last_id_nxt = last_id;
    grant_nxt   = grant;
    done_nxt    = '0;
    led_nxt     = led;
    unique case (state)
      IDLE: begin
        grant_nxt = '0;
        led_nxt   = LED_DARK;
        count_nxt = '0;
        if (pick_valid) begin
          state_nxt   = HOLD;
          grant_nxt   = NUM_REQ'(1) << pick_id;
          led_nxt     = ~color[3*32'(pick_id) +: COLOR_W];
          last_id_nxt = pick_id;
        end
      end
      HOLD: begin
        if (count == HOLD_LAST) begin
          state_nxt = GAP;
          count_nxt = '0;
          grant_nxt = '0;
          done_nxt  = grant;
          led_nxt   = LED_DARK;
        end else begin
          count_nxt = count + CNT_W'(1);
        end
      end
      GAP: begin
        led_nxt = LED_DARK;
        if (count == GAP_LAST) begin
          state_nxt = IDLE;
          count_nxt = '0;
        end else begin
          count_nxt = count + CNT_W'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
        count_nxt = '0;
        grant_nxt = '0;
        led_nxt   = LED_DARK;
      end
    endcase
    busy_nxt = (state_nxt != IDLE);
  end

  assign RGB_R = led[2];
  assign RGB_G = led[1];
  assign RGB_B = led[0];

endmodule

// File: tb/tb_rgb_led_arbiter.sv
// Directed bench for rgb_led_arbiter with a queue of expected grants checked as each grant appears.
module tb_rgb_led_arbiter;
  import rgb_pkg::*;

  localparam int unsigned N = 4;
  localparam int unsigned H = 8;
  localparam int unsigned G = 2;

  logic           clk;
  logic           rst_n;
  logic [N-1:0]   req;
  logic [3*N-1:0] color;
  logic [N-1:0]   grant;
  logic [N-1:0]   done;
  logic           busy;
  logic           RGB_R, RGB_G, RGB_B;

  typedef struct {
    int unsigned id;
    logic [2:0]  rgb;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;
  int unsigned cyc = 0;
  int unsigned last_grant_cyc = 0;

  rgb_led_arbiter #(
    .NUM_REQ     (N),
    .HOLD_CYCLES (H),
    .GAP_CYCLES  (G)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
    .color (color),
    .grant (grant),
    .done  (done),
    .busy  (busy),
    .RGB_R (RGB_R),
    .RGB_G (RGB_G),
    .RGB_B (RGB_B)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_color(input int unsigned i, input logic [2:0] c);
    color[3*i +: 3] = c;
  endtask

  task automatic expect_grant(input int unsigned id, input logic [2:0] c);
    exp_t e;
    e.id  = id;
    e.rgb = ~c;
    exp_q.push_back(e);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #3;
    rst_n = 1'b1;
    step();
  endtask

  // Waits for the next grant, pops its expectation and checks the full HOLD/GAP sequence
  task automatic run_grant(input bit clr_req, input bit mutate, output int unsigned waited,
                           output int unsigned gcyc);
    exp_t e;
    logic [N-1:0] oh;
    waited = 0;
    gcyc = 0;
    do begin
      step();
      waited++;
    end while (grant == '0 && waited < 40);
    if (grant == '0) begin
      chk("grant_seen", 32'(grant != '0), 32'd1);
      return;
    end
    gcyc = cyc;
    if (clr_req) req = '0;
    if (exp_q.size() == 0) begin
      chk("queue_nonempty", 32'(exp_q.size()), 32'd1);
      return;
    end
    e = exp_q.pop_front();
    oh = N'(1) << e.id;
    chk("grant_id", 32'(grant), 32'(oh));
    chk("grant_rgb", 32'({RGB_R, RGB_G, RGB_B}), 32'(e.rgb));
    chk("grant_busy", 32'(busy), 32'd1);
    for (int i = 1; i < int'(H); i++) begin
      if (mutate && i == 3) begin
        set_color(0, GREEN);
        req[0] = 1'b0;
      end
      step();
      chk("hold_grant", 32'(grant), 32'(oh));
      chk("hold_rgb", 32'({RGB_R, RGB_G, RGB_B}), 32'(e.rgb));
      chk("hold_done", 32'(done), 32'd0);
    end
    step();
    chk("gap_grant", 32'(grant), 32'd0);
    chk("gap_rgb", 32'({RGB_R, RGB_G, RGB_B}), 32'(LED_DARK));
    chk("gap_done", 32'(done), 32'(oh));
    chk("gap_busy", 32'(busy), 32'd1);
    step();
    chk("gap2_done", 32'(done), 32'd0);
    chk("gap2_busy", 32'(busy), 32'd1);
    step();
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_rgb", 32'({RGB_R, RGB_G, RGB_B}), 32'(LED_DARK));
  endtask

  initial begin
    int unsigned w;
    int unsigned g;
    int unsigned prev;
    req   = '0;
    color = '0;
    rst_n = 1'b1;

    // Async reset with no clock edge
    #1 rst_n = 1'b0;
    #1;
    chk("rst_rgb", 32'({RGB_R, RGB_G, RGB_B}), 32'h7);
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    #10 rst_n = 1'b1;
    step();

    // Single request, one-cycle latency
    set_color(2, RED);
    expect_grant(2, RED);
    req = 4'b0100;
    run_grant(1'b1, 1'b0, w, g);
    chk("single_latency", 32'(w), 32'd1);

    // Round-robin fairness from a fresh reset
    do_reset();
    for (int i = 0; i < 4; i++) set_color(i, 3'(i + 1));
    for (int i = 0; i < 4; i++) expect_grant(i, 3'(i + 1));
    expect_grant(0, 3'd1);
    req = 4'b1111;
    run_grant(1'b0, 1'b0, w, g);
    prev = g;
    for (int i = 0; i < 4; i++) begin
      run_grant(i == 3, 1'b0, w, g);
      chk("rr_period", g - prev, 32'(1 + H + G));
      prev = g;
    end

    // Colour change and request drop mid-HOLD are ignored
    set_color(0, BLUE);
    expect_grant(0, BLUE);
    req = 4'b0001;
    run_grant(1'b0, 1'b1, w, g);
    step();
    chk("mid_no_regrant", 32'(grant), 32'd0);

    // Async reset in the middle of HOLD
    set_color(0, RED);
    req = 4'b0001;
    w = 0;
    do begin
      step();
      w++;
    end while (grant == '0 && w < 40);
    chk("arst_pre_grant", 32'(grant), 32'd1);
    req = '0;
    step();
    step();
    step();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_rgb", 32'({RGB_R, RGB_G, RGB_B}), 32'h7);
    chk("arst_grant", 32'(grant), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    #4 rst_n = 1'b1;
    step();
    set_color(1, CYAN);
    set_color(3, MAGENTA);
    expect_grant(1, CYAN);
    expect_grant(3, MAGENTA);
    req = 4'b1010;
    run_grant(1'b0, 1'b0, w, g);
    prev = g;
    run_grant(1'b1, 1'b0, w, g);
    chk("arst_rr_period", g - prev, 32'(1 + H + G));

    // Black colour still produces the full grant/done sequence
    set_color(0, RGB_OFF);
    expect_grant(0, RGB_OFF);
    req = 4'b0001;
    run_grant(1'b1, 1'b0, w, g);

    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
